sseg_scan_decoder: RTL

//  Receive side of the multiplexed 4-digit seven-segment display bus (anodos/SSegm) driven by the temperature-alarm controller.

---
 rtl/sseg_scan_decoder.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/sseg_scan_decoder.sv
// sseg_scan_decoder: recovers hex digits and dps from a scanned 4-digit 7-seg bus.
// Optional GLITCH_COUNT_EN adds glitch_cnt_o (stable multi-anode pattern count).
module sseg_scan_decoder #(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 65536,
  parameter bit ACT_LOW     = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  anodos_i,
  input  logic [7:0]  SSegm_i,
  output logic [15:0] digits_o,
  output logic [3:0]  dp_o,
  output logic [3:0]  digit_err_o,
  output logic        frame_stb_o,
  output logic        frame_valid_o,
`ifdef GLITCH_COUNT_EN
  output logic [7:0]  glitch_cnt_o,
`endif
  output logic        scan_idle_o
);

  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] SET_M1  = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] SET_MAX = CW'(SETTLE_CYC);
  localparam logic [TW-1:0] T_MAX   = TW'(TIMEOUT_CYC - 1);
  localparam logic [11:0]   IDLE_PAT = ACT_LOW ? 12'hFFF : 12'h000;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_CAPT = 2'd1,
    S_HELD = 2'd2
  } state_t;

  state_t state_q;

  logic [11:0]   in_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [15:0]   dig_q, dig_d;
  logic [3:0]    dp_q, dp_d;
  logic [3:0]    err_q, err_d;
  logic [3:0]    mask_q, mask_d;
  logic          stb_q, stb_d;
  logic          valid_q, valid_d;
  logic          idle_q, idle_d;

  logic [11:0] norm;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        chg, onehot, stable_hit, cap;
  logic [3:0]  cap_bits;
  logic [4:0]  gl;

  // Returns {err, nibble}; anything that is not a hex glyph is an error.
  function automatic logic [4:0] glyph(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h3F:   r = 5'h00;
      7'h06:   r = 5'h01;
      7'h5B:   r = 5'h02;
      7'h4F:   r = 5'h03;
      7'h66:   r = 5'h04;
      7'h6D:   r = 5'h05;
      7'h7D:   r = 5'h06;
      7'h07:   r = 5'h07;
      7'h7F:   r = 5'h08;
      7'h6F:   r = 5'h09;
      7'h77:   r = 5'h0A;
      7'h7C:   r = 5'h0B;
      7'h39:   r = 5'h0C;
      7'h5E:   r = 5'h0D;
      7'h79:   r = 5'h0E;
      7'h71:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  assign norm = ACT_LOW ? ~in_q : in_q;
  assign an   = norm[11:8];
  assign seg  = norm[7:0];
  assign chg  = (in_q != prev_q);

  assign onehot = (an != 4'h0) &&
                  ((an & (an - 4'd1)) == 4'h0);

  assign stable_hit = !chg && (cnt_q == SET_M1);
  assign cap = (state_q == S_WAIT) && stable_hit && onehot;
  assign cap_bits = cap ? an : 4'h0;
  assign gl = glyph(seg[6:0]);

  always_comb begin
    cnt_d = cnt_q;
    if (chg)
      cnt_d = '0;
    else if (cnt_q != SET_MAX)
      cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    dig_d   = dig_q;
    dp_d    = dp_q;
    err_d   = err_q;
    mask_d  = mask_q;
    stb_d   = 1'b0;
    valid_d = valid_q;
    idle_d  = idle_q;
    tcnt_d  = tcnt_q;
    for (int n = 0; n < 4; n++) begin
      if (cap_bits[n]) begin
        dig_d[4*n +: 4] = gl[3:0];
        dp_d[n]         = seg[7];
        err_d[n]        = gl[4];
      end
    end
    // A digit captured while the full mask retires starts the next frame.
    if (mask_q == 4'hF) begin
      stb_d   = 1'b1;
      valid_d = 1'b1;
      mask_d  = cap_bits;
    end else begin
      mask_d  = mask_q | cap_bits;
    end
    if (cap) begin
      tcnt_d = '0;
      idle_d = 1'b0;
    end else if (tcnt_q == T_MAX) begin
      idle_d  = 1'b1;
      valid_d = 1'b0;
      mask_d  = 4'h0;
    end else begin
      tcnt_d = tcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_WAIT;
      in_q    <= IDLE_PAT;
      prev_q  <= IDLE_PAT;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      dig_q   <= '0;
      dp_q    <= '0;
      err_q   <= '0;
      mask_q  <= '0;
      stb_q   <= 1'b0;
      valid_q <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      in_q    <= {anodos_i, SSegm_i};
      prev_q  <= in_q;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      dig_q   <= dig_d;
      dp_q    <= dp_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      stb_q   <= stb_d;
      valid_q <= valid_d;
      idle_q  <= idle_d;
      unique case (state_q)
        S_WAIT:  if (cap) state_q <= S_CAPT;
        S_CAPT:  state_q <= S_HELD;
        S_HELD:  if (chg || cnt_q == '0)
                   state_q <= S_WAIT;
        default: state_q <= S_WAIT;
      endcase
    end
  end

`ifdef GLITCH_COUNT_EN
  logic [7:0] glitch_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      glitch_q <= 8'h00;
    else if (stable_hit && !onehot &&
             an != 4'h0 && glitch_q != 8'hFF)
      glitch_q <= glitch_q + 8'd1;
  end

  assign glitch_cnt_o = glitch_q;
`endif

  assign digits_o      = dig_q;
  assign dp_o          = dp_q;
  assign digit_err_o   = err_q;
  assign frame_stb_o   = stb_q;
  assign frame_valid_o = valid_q;
  assign scan_idle_o   = idle_q;

endmodule
